// File: rtl/misr_pkg.sv
// Shared definitions for the multiple-input signature register:
// run-control state encoding and default 16-bit polynomial/seed.
package misr_pkg;

   // Run-control states; encoding kept stable for legacy state decoders.
   typedef enum logic [1:0] {
      MISR_IDLE = 2'd0,
      MISR_RUN  = 2'd1,
      MISR_DONE = 2'd2
   } misr_state_e;

   // Default feedback taps (bit i set => MSB folded into bit i) and seed
   // for the 16-bit compactor.
   localparam logic [15:0] MISR_POLY16 = 16'h002D;
   localparam logic [15:0] MISR_SEED16 = 16'h8000;

endpackage

// File: rtl/misr_step.sv
// One compaction step of the signature register: shift left by one,
// fold the old MSB into the tap positions, and XOR in the data word.
// Purely combinational so multi-channel variants can chain copies.
module misr_step
   import misr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY16)
) (
   input  logic [WIDTH-1:0] sig,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] next_sig
);

   logic fb;

   assign fb = sig[WIDTH-1];

   // Bit 0 always takes the feedback; higher bits take it only where tapped.
   always_comb begin
      next_sig    = '0;
      next_sig[0] = fb ^ data[0];
      for (int i = 1; i < WIDTH; i++) begin
         next_sig[i] = sig[i-1] ^ (POLY[i] & fb) ^ data[i];
      end
   end

endmodule

// File: rtl/misr_gen.sv
// Programmable-length MISR for the radix-4 BIST path. Compacts
// NUM_PATTERNS valid words per run, then compares against golden.
//
// Handshake: a one-cycle start pulse (accepted in any state, and taking
// priority over data_valid) reseeds and opens a run; busy is high while
// words are being accepted; ready rises the cycle after the final valid
// word and stays high until the next start, and pass is meaningful only
// while ready is high. data_valid is ignored outside RUN.
module misr_gen
   import misr_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] POLY         = WIDTH'(MISR_POLY16),
   parameter logic [WIDTH-1:0] SEED         = WIDTH'(MISR_SEED16),
   parameter int               NUM_PATTERNS = 32,
   parameter int               CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
   input  logic             clk,
   input  logic             reset_to_misr,
   input  logic             start,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] signature,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             ready,
   output logic             pass,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] S_IDLE = MISR_IDLE;
   localparam logic [1:0] S_RUN  = MISR_RUN;
   localparam logic [1:0] S_DONE = MISR_DONE;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_PATTERNS);

   logic [1:0]       state_q;
   logic [WIDTH-1:0] sig_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             ready_q;
   logic             pass_q;
   logic [WIDTH-1:0] next_sig;

   misr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .sig      (sig_q),
      .data     (data_in),
      .next_sig (next_sig)
   );

   // Run control: start reseeds from any state; in RUN each valid word is
   // compacted and the last one closes the run and latches the verdict.
   always_ff @(posedge clk or negedge reset_to_misr) begin
      if (!reset_to_misr) begin
         state_q <= S_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         pass_q  <= 1'b0;
      end else if (start) begin
         state_q <= S_RUN;
         sig_q   <= SEED;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (data_valid) begin
                  sig_q <= next_sig;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= S_DONE;
                     cnt_q   <= CNT_FULL;
                     busy_q  <= 1'b0;
                     ready_q <= 1'b1;
                     pass_q  <= (next_sig == golden);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            S_IDLE, S_DONE: begin
               // Hold everything until the next start.
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign signature = sig_q;
   assign count     = cnt_q;
   assign busy      = busy_q;
   assign ready     = ready_q;
   assign pass      = pass_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_misr_gen.sv
// Directed bench for misr_gen: one single-word instance and one default
// 32-word instance, checked against hand values and a shift/XOR model.
module tb_misr_gen;

   localparam int          W    = 16;
   localparam logic [15:0] P16  = 16'h002D;
   localparam logic [15:0] S16  = 16'h8000;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- DUT A: NUM_PATTERNS = 1 ----------------
   logic         a_start, a_valid;
   logic [W-1:0] a_data, a_golden, a_sig;
   logic [0:0]   a_count;
   logic         a_busy, a_ready, a_pass;
   logic [1:0]   a_state;

   misr_gen #(.NUM_PATTERNS(1)) dut_a (
      .clk           (clk),
      .reset_to_misr (rst_n),
      .start         (a_start),
      .data_valid    (a_valid),
      .data_in       (a_data),
      .golden        (a_golden),
      .signature     (a_sig),
      .count         (a_count),
      .busy          (a_busy),
      .ready         (a_ready),
      .pass          (a_pass),
      .state_dbg     (a_state)
   );

   // ---------------- DUT B: NUM_PATTERNS = 32 ----------------
   logic         b_start, b_valid;
   logic [W-1:0] b_data, b_golden, b_sig;
   logic [5:0]   b_count;
   logic         b_busy, b_ready, b_pass;
   logic [1:0]   b_state;

   misr_gen dut_b (
      .clk           (clk),
      .reset_to_misr (rst_n),
      .start         (b_start),
      .data_valid    (b_valid),
      .data_in       (b_data),
      .golden        (b_golden),
      .signature     (b_sig),
      .count         (b_count),
      .busy          (b_busy),
      .ready         (b_ready),
      .pass          (b_pass),
      .state_dbg     (b_state)
   );

   // ---------------- scoreboard ----------------
   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] b_model;
   logic [W-1:0] words[32];
   logic [W-1:0] gapfree_sig;
   logic [W-1:0] hold_sig;
   logic [5:0]   hold_cnt;
   logic         hold_pass;

   // Reference step written as shift, conditional polynomial XOR, data XOR.
   function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] d);
      logic [15:0] r;
      r = {s[14:0], 1'b0} ^ d;
      if (s[15]) r = r ^ P16;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic b_begin();
      b_start = 1'b1;
      b_valid = 1'b0;
      tick();
      b_start = 1'b0;
      b_model = S16;
      exp_q.delete();
      check("b_start_sig", 32'(b_sig), 32'(S16));
      check("b_start_cnt", 32'(b_count), 32'd0);
      check("b_start_busy", 32'(b_busy), 32'd1);
      check("b_start_ready", 32'(b_ready), 32'd0);
   endtask

   task automatic b_push(input logic [15:0] d);
      b_valid = 1'b1;
      b_data  = d;
      b_model = model_step(b_model, d);
      exp_q.push_back(b_model);
      tick();
      b_valid = 1'b0;
      check("b_word_sig", 32'(b_sig), 32'(exp_q.pop_front()));
   endtask

   task automatic b_gap(input int n);
      b_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         b_data = 16'($urandom);
         tick();
         check("b_gap_sig", 32'(b_sig), 32'(b_model));
         check("b_gap_busy", 32'(b_busy), 32'd1);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n    = 1'b0;
      a_start  = 1'b0; a_valid = 1'b0; a_data = '0; a_golden = '0;
      b_start  = 1'b0; b_valid = 1'b0; b_data = '0; b_golden = '0;
      for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
      words[0] = 16'h0000;
      words[1] = 16'h0000;

      // Reset state
      repeat (2) tick();
      check("rst_a_sig", 32'(a_sig), 32'h8000);
      check("rst_a_cnt", 32'(a_count), 32'd0);
      check("rst_b_sig", 32'(b_sig), 32'h8000);
      check("rst_b_flags", 32'({b_busy, b_ready, b_pass}), 32'd0);
      rst_n = 1'b1;
      tick();

      // data_valid ignored in IDLE
      a_valid = 1'b1; a_data = 16'hFFFF;
      tick();
      a_valid = 1'b0;
      check("idle_a_sig", 32'(a_sig), 32'h8000);
      check("idle_a_busy", 32'(a_busy), 32'd0);

      // Single word 0x0000, golden 0x002D -> pass
      a_start = 1'b1; tick(); a_start = 1'b0;
      check("a1_busy", 32'(a_busy), 32'd1);
      a_valid = 1'b1; a_data = 16'h0000; a_golden = 16'h002D;
      tick();
      a_valid = 1'b0;
      check("a1_sig", 32'(a_sig), 32'h002D);
      check("a1_ready", 32'(a_ready), 32'd1);
      check("a1_cnt", 32'(a_count), 32'd1);
      check("a1_pass", 32'(a_pass), 32'd1);
      check("a1_busy_off", 32'(a_busy), 32'd0);
      a_golden = 16'h0000;
      tick();
      check("a1_pass_frozen", 32'(a_pass), 32'd1);

      // Single word 0x0001, golden 0x002D -> fail verdict
      a_start = 1'b1; tick(); a_start = 1'b0;
      check("a2_ready_clr", 32'(a_ready), 32'd0);
      a_valid = 1'b1; a_data = 16'h0001; a_golden = 16'h002D;
      tick();
      a_valid = 1'b0;
      check("a2_sig", 32'(a_sig), 32'h002C);
      check("a2_ready", 32'(a_ready), 32'd1);
      check("a2_pass", 32'(a_pass), 32'd0);

      // 32 words gap-free; first two words zero give hand value 0x005A
      b_begin();
      b_push(words[0]);
      check("b_hand_w0", 32'(b_sig), 32'h002D);
      b_push(words[1]);
      check("b_hand_w1", 32'(b_sig), 32'h005A);
      for (int i = 2; i < 31; i++) b_push(words[i]);
      check("b_nf_ready_early", 32'(b_ready), 32'd0);
      check("b_nf_cnt31", 32'(b_count), 32'd31);
      b_golden = model_step(b_model, words[31]);
      b_push(words[31]);
      gapfree_sig = b_model;
      check("b_nf_ready", 32'(b_ready), 32'd1);
      check("b_nf_cnt", 32'(b_count), 32'd32);
      check("b_nf_pass", 32'(b_pass), 32'd1);

      // Same words with gaps; golden deliberately wrong
      b_golden = ~gapfree_sig;
      b_begin();
      for (int i = 0; i < 31; i++) begin
         b_push(words[i]);
         if (i % 4 == 1) b_gap(int'($urandom_range(1, 3)));
      end
      check("b_gap_ready_early", 32'(b_ready), 32'd0);
      b_gap(2);
      b_push(words[31]);
      check("b_gap_final", 32'(b_sig), 32'(gapfree_sig));
      check("b_gap_ready", 32'(b_ready), 32'd1);
      check("b_gap_pass", 32'(b_pass), 32'd0);

      // Restart after 10 words; the start cycle's word is discarded
      b_begin();
      for (int i = 0; i < 10; i++) b_push(16'($urandom));
      b_start = 1'b1; b_valid = 1'b1; b_data = 16'hFFFF;
      tick();
      b_start = 1'b0; b_valid = 1'b0;
      b_model = S16;
      check("b_rs_sig", 32'(b_sig), 32'h8000);
      check("b_rs_cnt", 32'(b_count), 32'd0);
      check("b_rs_busy", 32'(b_busy), 32'd1);
      b_golden = 16'h0000;
      for (int i = 0; i < 31; i++) b_push(words[i]);
      check("b_rs_ready_early", 32'(b_ready), 32'd0);
      b_push(words[31]);
      check("b_rs_final", 32'(b_sig), 32'(gapfree_sig));
      check("b_rs_ready", 32'(b_ready), 32'd1);

      // DONE: activity on data_valid has no effect
      hold_sig = b_sig; hold_cnt = b_count; hold_pass = b_pass;
      check("b_done_pass0", 32'(hold_pass), 32'(gapfree_sig == 16'h0000));
      for (int k = 0; k < 6; k++) begin
         b_valid = 1'($urandom_range(0, 1));
         b_data  = 16'($urandom);
         tick();
         check("b_done_sig", 32'(b_sig), 32'(gapfree_sig));
         check("b_done_cnt", 32'(b_count), 32'd32);
         check("b_done_pass", 32'(b_pass), 32'(hold_pass));
      end
      b_valid = 1'b0;
      b_begin();
      check("b_new_pass", 32'(b_pass), 32'd0);

      // Asynchronous reset between edges mid-run
      for (int i = 0; i < 5; i++) b_push(words[i + 2] ^ 16'h5A5A);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("ar_sig", 32'(b_sig), 32'h8000);
      check("ar_cnt", 32'(b_count), 32'd0);
      check("ar_flags", 32'({b_busy, b_ready, b_pass}), 32'd0);
      check("ar_state", 32'(b_state), 32'd0);
      check("ar_a_flags", 32'({a_busy, a_ready, a_pass}), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      check("ar_hold_idle", 32'(b_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/misr_gen.md
# misr_gen

Parametrised multiple-input signature register for the radix-4 BIST path: compacts a programmable number of WIDTH-bit result words into a signature using a configurable polynomial and seed. Compaction is gated by a per-word valid, and a start/ready handshake frames each run. At end of run it compares the signature against a supplied golden value. It sits after the radix-4 datapath and replaces the fixed 16-bit, fixed-count compactor.

## Interface
- WIDTH, 16: signature and data width (≥2)
- POLY, 16'h002D: feedback taps; bit i set ⇒ MSB XORed into bit i (bit 0 must be set)
- SEED, 16'h8000: signature value loaded at reset and at start (WIDTH bits)
- NUM_PATTERNS, 32: words compacted per run (≥1)
- CNT_W, $clog2(NUM_PATTERNS+1): counter width (derived)

- clk  in  1  single clock, rising edge
- reset_to_misr  in  1  asynchronous, active-low reset
- start  in  1  begin (or restart) a run, one-cycle pulse
- data_valid  in  1  data_in is a valid word this cycle
- data_in  in  WIDTH  result word from radix-4 datapath
- golden  in  WIDTH  expected signature, sampled at run completion
- signature  out  WIDTH  current signature
- count  out  CNT_W  words compacted in current run
- busy  out  1  high in RUN
- ready  out  1  high in DONE (run complete)
- pass  out  1  signature == golden at completion; valid only while ready

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, reset_to_misr=0): state IDLE, signature=SEED, count=0, busy=0, ready=0, pass=0.
- IDLE: data_valid ignored; start → RUN, signature←SEED, count←0.
- RUN, data_valid=1: next[0]=sig[MSB]^d[0]; next[i]=sig[i-1]^(POLY[i]&sig[MSB])^d[i] for i≥1; count+1.
- RUN, data_valid=0: signature and count hold.
- RUN, data_valid=1 with count==NUM_PATTERNS-1: final word compacted; → DONE; pass←(next==golden); count←NUM_PATTERNS.
- DONE: signature, count, pass frozen; data_valid ignored; start → RUN (reseed, count 0, ready/pass cleared).
- start in RUN: restart; reseed, count←0, that cycle's data_valid discarded. start has priority over data_valid in all states.
- Arithmetic is pure GF(2); count never wraps (saturates at NUM_PATTERNS).

## Timing
- All outputs registered.
- Signature update visible the cycle after the valid edge; 1-cycle latency.
- busy rises the cycle after start; ready and pass rise the cycle after the final valid word.
- Minimum run length NUM_PATTERNS cycles with data_valid held high.
- golden sampled only on the completing edge.
- Reset mid-run aborts immediately; no partial ready.

## Structure
- Package misr_pkg: state enum (IDLE/RUN/DONE), default POLY/SEED constants for WIDTH 16.
- Sub-module misr_step: combinational next-signature function (sig, data, POLY) → next; reused by future multi-channel variants.

## Test plan
- Defaults, NUM_PATTERNS=1, start then data_in=0x0000 valid → signature 0x002D, ready=1 one cycle later, count=1; golden=0x002D → pass=1.
- Same with data_in=0x0001 → signature 0x002C; golden=0x002D → pass=0.
- 32 words with gaps of data_valid=0 between → final signature equals gap-free run with same words; ready only after 32nd valid.
- start asserted after 10 words of a run → signature 0x8000, count 0, busy stays 1; run then completes after 32 further words.
- Reset driven low mid-run, asynchronously between edges → signature 0x8000, count 0, busy/ready/pass 0 immediately.
- In DONE: data_valid toggling with random data → signature, count, pass unchanged; start → new run from 0x8000.
